// File: rtl/snake_move_module.sv
// Snake motion and collision engine: segment shift register, step timing, key steering and
// registered pixel query. Define SNAKE_WRAP_EN to wrap at grid edges instead of flagging walls.
module snake_move_module #(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned STEP_DIV = 6000000
) (
  input  logic       Clk_24mhz,
  input  logic       Rst,
  input  logic       Key_left,
  input  logic       Key_right,
  input  logic       Key_up,
  input  logic       Key_down,
  input  logic [2:0] Game_status,
  input  logic [5:0] Apple_x,
  input  logic [4:0] Apple_y,
  input  logic [5:0] Pix_x,
  input  logic [4:0] Pix_y,
  output logic       Snake_pix,
  output logic       Head_pix,
  output logic [5:0] Head_x,
  output logic [4:0] Head_y,
  output logic [4:0] Length,
  output logic       Hit_wall_sig,
  output logic       Hit_body_sig,
  output logic       Apple_eaten,
  output logic       Step_pulse
);

  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;

  // Encoding chosen so that the reverse direction is dir ^ 1.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int unsigned CntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [5:0] X0 = 6'(GRID_W / 2);
  localparam logic [4:0] Y0 = 5'(GRID_H / 2);

  logic [5:0]      seg_x_q [MAX_LEN];
  logic [5:0]      seg_x_d [MAX_LEN];
  logic [4:0]      seg_y_q [MAX_LEN];
  logic [4:0]      seg_y_d [MAX_LEN];
  logic [4:0]      len_q, len_d;
  logic [1:0]      dir_q, dir_d, pend_q, pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wall_q, wall_d, body_q, body_d;
  logic            eaten_q, eaten_d, step_q, step_d;
  logic            spix_q, spix_d, hpix_q, hpix_d;

  logic [5:0] nx;
  logic [4:0] ny;
  logic       off_grid, wall_hit, body_hit, apple_hit, tick, key_vld;
  logic [1:0] key_dir, ref_dir;

  // Next head; off-grid values are pre-wrapped so the wrap build needs no extra logic.
  always_comb begin
    nx       = seg_x_q[0];
    ny       = seg_y_q[0];
    off_grid = 1'b0;
    case (pend_q)
      DIR_UP: begin
        if (seg_y_q[0] == '0) begin
          off_grid = 1'b1;
          ny       = 5'(GRID_H - 1);
        end else ny = seg_y_q[0] - 5'd1;
      end
      DIR_DOWN: begin
        if (seg_y_q[0] == 5'(GRID_H - 1)) begin
          off_grid = 1'b1;
          ny       = '0;
        end else ny = seg_y_q[0] + 5'd1;
      end
      DIR_LEFT: begin
        if (seg_x_q[0] == '0) begin
          off_grid = 1'b1;
          nx       = 6'(GRID_W - 1);
        end else nx = seg_x_q[0] - 6'd1;
      end
      default: begin
        if (seg_x_q[0] == 6'(GRID_W - 1)) begin
          off_grid = 1'b1;
          nx       = '0;
        end else nx = seg_x_q[0] + 6'd1;
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = off_grid;
`endif

  // Tail (index Length-1) is excluded: it vacates on the same step.
  always_comb begin
    body_hit = 1'b0;
    for (int i = 0; i < int'(MAX_LEN) - 1; i++) begin
      if ((i + 2 <= int'(len_q)) && (seg_x_q[i] == nx) && (seg_y_q[i] == ny)) body_hit = 1'b1;
    end
  end

  always_comb begin
    key_vld = Key_up | Key_down | Key_left | Key_right;
    if (Key_up)        key_dir = DIR_UP;
    else if (Key_down) key_dir = DIR_DOWN;
    else if (Key_left) key_dir = DIR_LEFT;
    else               key_dir = DIR_RIGHT;
  end

  always_comb begin
    spix_d = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((i < int'(len_q)) && (seg_x_q[i] == Pix_x) && (seg_y_q[i] == Pix_y)) spix_d = 1'b1;
    end
    hpix_d = (seg_x_q[0] == Pix_x) && (seg_y_q[0] == Pix_y);
  end

  always_comb begin
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    len_d     = len_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    wall_d    = wall_q;
    body_d    = body_q;
    eaten_d   = 1'b0;
    step_d    = 1'b0;
    tick      = (cnt_q == CntW'(STEP_DIV - 1));
    // A key in the terminal cycle is judged against the direction about to be committed.
    ref_dir   = tick ? pend_q : dir_q;
    apple_hit = (nx == Apple_x) && (ny == Apple_y);
    if (Game_status == ST_START) begin
      seg_x_d[0] = X0;
      seg_x_d[1] = X0 - 6'd1;
      seg_x_d[2] = X0 - 6'd2;
      seg_y_d[0] = Y0;
      seg_y_d[1] = Y0;
      seg_y_d[2] = Y0;
      len_d      = 5'd3;
      dir_d      = DIR_RIGHT;
      pend_d     = DIR_RIGHT;
      cnt_d      = '0;
      wall_d     = 1'b0;
      body_d     = 1'b0;
    end else if ((Game_status == ST_PLAY) && !wall_q && !body_q) begin
      if (key_vld && (key_dir != (ref_dir ^ 2'b01))) pend_d = key_dir;
      if (tick) begin
        cnt_d  = '0;
        step_d = 1'b1;
        dir_d  = pend_q;
        if (wall_hit) begin
          wall_d = 1'b1;
        end else if (body_hit) begin
          body_d = 1'b1;
        end else begin
          for (int i = 1; i < int'(MAX_LEN); i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nx;
          seg_y_d[0] = ny;
          if (apple_hit) begin
            eaten_d = 1'b1;
            if (len_q < 5'(MAX_LEN)) len_d = len_q + 5'd1;
          end
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge Clk_24mhz or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= '0;
        seg_y_q[i] <= '0;
      end
      seg_x_q[0] <= X0;
      seg_x_q[1] <= X0 - 6'd1;
      seg_x_q[2] <= X0 - 6'd2;
      seg_y_q[0] <= Y0;
      seg_y_q[1] <= Y0;
      seg_y_q[2] <= Y0;
      len_q      <= 5'd3;
      dir_q      <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      cnt_q      <= '0;
      wall_q     <= 1'b0;
      body_q     <= 1'b0;
      eaten_q    <= 1'b0;
      step_q     <= 1'b0;
      spix_q     <= 1'b0;
      hpix_q     <= 1'b0;
    end else begin
      seg_x_q    <= seg_x_d;
      seg_y_q    <= seg_y_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      wall_q     <= wall_d;
      body_q     <= body_d;
      eaten_q    <= eaten_d;
      step_q     <= step_d;
      spix_q     <= spix_d;
      hpix_q     <= hpix_d;
    end
  end

  assign Head_x       = seg_x_q[0];
  assign Head_y       = seg_y_q[0];
  assign Length       = len_q;
  assign Hit_wall_sig = wall_q;
  assign Hit_body_sig = body_q;
  assign Apple_eaten  = eaten_q;
  assign Step_pulse   = step_q;
  assign Snake_pix    = spix_q;
  assign Head_pix     = hpix_q;

endmodule
